// File: rtl/nes_pkg.sv
// Shared NES definitions: CPU-visible register addresses and the OAM DMA state encoding.
package nes_pkg;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        OAM_IDLE,
        OAM_HALT,
        OAM_ALIGN,
        OAM_READ,
        OAM_WRITE
    } oam_dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies a 256-byte CPU page into the PPU OAM data port,
// halting the CPU and aligning the first read to an even cycle.
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_wr_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic [7:0]  bus_din,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rd_en,
    output logic        dma_wr_en,
    output logic [7:0]  dma_dout
);

    oam_dma_state_t state_reg;
    logic           parity_reg;
    logic [7:0]     page_reg;
    logic [7:0]     index_reg;
    logic [7:0]     data_reg;
    logic [15:0]    addr_reg;
    logic           rd_en_reg;
    logic           wr_en_reg;
    logic           trigger;

    assign trigger = cpu_wr_en && (cpu_addr == DMA_REG_ADDR);

    // Bus strobes and address are registered alongside the state transition,
    // so they line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= OAM_IDLE;
            parity_reg <= 1'b0;
            page_reg   <= 8'h00;
            index_reg  <= 8'h00;
            data_reg   <= 8'h00;
            addr_reg   <= 16'h0000;
            rd_en_reg  <= 1'b0;
            wr_en_reg  <= 1'b0;
        end else begin
            parity_reg <= ~parity_reg;
            rd_en_reg  <= 1'b0;
            wr_en_reg  <= 1'b0;
            case (state_reg)
                OAM_IDLE: begin
                    if (trigger) begin
                        page_reg  <= cpu_din;
                        index_reg <= 8'h00;
                        state_reg <= OAM_HALT;
                    end
                end
                OAM_HALT: begin
                    // parity_reg is 1 here exactly when the next cycle is even
                    if (parity_reg) begin
                        state_reg <= OAM_READ;
                        addr_reg  <= {page_reg, index_reg};
                        rd_en_reg <= 1'b1;
                    end else begin
                        state_reg <= OAM_ALIGN;
                    end
                end
                OAM_ALIGN: begin
                    state_reg <= OAM_READ;
                    addr_reg  <= {page_reg, index_reg};
                    rd_en_reg <= 1'b1;
                end
                OAM_READ: begin
                    data_reg  <= bus_din;
                    state_reg <= OAM_WRITE;
                    addr_reg  <= OAM_DATA_ADDR;
                    wr_en_reg <= 1'b1;
                end
                OAM_WRITE: begin
                    index_reg <= index_reg + 8'd1;
                    if (index_reg == 8'hFF) begin
                        state_reg <= OAM_IDLE;
                    end else begin
                        state_reg <= OAM_READ;
                        addr_reg  <= {page_reg, index_reg + 8'd1};
                        rd_en_reg <= 1'b1;
                    end
                end
                default: state_reg <= OAM_IDLE;
            endcase
        end
    end

    assign dma_active = (state_reg != OAM_IDLE);
    assign dma_addr   = addr_reg;
    assign dma_rd_en  = rd_en_reg;
    assign dma_wr_en  = wr_en_reg;
    assign dma_dout   = data_reg;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: even/odd triggers, ignored re-triggers,
// mid-transfer reset and the ROM vector page.
module tb_oam_dma;
    import nes_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_wr_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  bus_din;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rd_en;
    logic        dma_wr_en;
    logic [7:0]  dma_dout;

    int          n_checks = 0;
    int          n_err = 0;
    logic [7:0]  wlog [256];

    always #5 clock = ~clock;

    oam_dma dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .bus_din    (bus_din),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_rd_en  (dma_rd_en),
        .dma_wr_en  (dma_wr_en),
        .dma_dout   (dma_dout)
    );

    // RAM returns low address XOR A5; the top of page FF holds the CPU vectors.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'hFFFA: mem_byte = 8'h10;
            16'hFFFB: mem_byte = 8'h80;
            16'hFFFC: mem_byte = 8'h00;
            16'hFFFD: mem_byte = 8'h80;
            16'hFFFE: mem_byte = 8'h20;
            16'hFFFF: mem_byte = 8'h80;
            default:  mem_byte = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always_comb bus_din = mem_byte(dma_addr);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; drives the trigger in the current cycle and follows the transfer.
    task automatic run_transfer(input logic [7:0] page, input int exp_len, input int inject_at,
                                input int abort_idx, input logic [7:0] exp_first,
                                input logic [7:0] exp_last, input string name);
        int          len = 0;
        int          nostrobe = 0;
        int          rd_idx = 0;
        int          wr_idx = 0;
        int          cyc = 0;
        logic [15:0] first_rd = 16'h0000;
        logic [15:0] last_rd = 16'h0000;
        bit          done = 0;
        bit          aborted = 0;

        cpu_wr_en = 1'b1;
        cpu_addr  = ADDR_OAMDMA;
        cpu_din   = page;
        @(negedge clock);
        cpu_wr_en = 1'b0;
        chk({name, " halt_active"}, {15'd0, dma_active}, 16'd1);
        chk({name, " halt_no_strobe"}, {14'd0, dma_rd_en, dma_wr_en}, 16'd0);

        while (!done && cyc < 600) begin
            cpu_wr_en = 1'b0;
            if (!dma_active) begin
                done = 1;
            end else begin
                len++;
                if (dma_rd_en && dma_wr_en)
                    chk({name, " both_strobes"}, {14'd0, dma_rd_en, dma_wr_en}, 16'd2);
                if (dma_rd_en) begin
                    chk({name, " rd_addr"}, dma_addr, {page, rd_idx[7:0]});
                    if (rd_idx == 0) first_rd = dma_addr;
                    last_rd = dma_addr;
                    if (rd_idx == abort_idx) begin
                        reset     = 1'b1;
                        cpu_wr_en = 1'b1;
                        cpu_addr  = ADDR_OAMDMA;
                        cpu_din   = 8'h07;
                        aborted   = 1;
                    end
                    rd_idx++;
                end else if (dma_wr_en) begin
                    chk({name, " wr_addr"}, dma_addr, 16'h2004);
                    chk({name, " wr_data"}, {8'd0, dma_dout}, {8'd0, mem_byte({page, wr_idx[7:0]})});
                    wlog[wr_idx[7:0]] = dma_dout;
                    wr_idx++;
                    if (wr_idx == inject_at) begin
                        cpu_wr_en = 1'b1;
                        cpu_addr  = ADDR_OAMDMA;
                        cpu_din   = 8'h07;
                    end
                end else begin
                    nostrobe++;
                end
            end
            if (aborted) begin
                @(negedge clock);
                reset     = 1'b0;
                cpu_wr_en = 1'b0;
                chk({name, " abort_active"}, {15'd0, dma_active}, 16'd0);
                chk({name, " abort_strobes"}, {14'd0, dma_rd_en, dma_wr_en}, 16'd0);
                chk({name, " abort_addr"}, dma_addr, 16'h0000);
                chk({name, " abort_dout"}, {8'd0, dma_dout}, 16'h0000);
                $display("%s: page %h aborted by reset at read index %0d", name, page, rd_idx - 1);
                return;
            end
            if (!done) begin
                @(negedge clock);
                cyc++;
            end
        end

        if (!done) begin
            n_checks++;
            n_err++;
            $error("FAIL %s timeout: observed active cycles %0d expected %0d", name, len, exp_len);
            return;
        end

        chk({name, " active_len"}, len[15:0], exp_len[15:0]);
        chk({name, " halt_align_cycles"}, nostrobe[15:0], exp_len[15:0] - 16'd512);
        chk({name, " reads"}, rd_idx[15:0], 16'd256);
        chk({name, " writes"}, wr_idx[15:0], 16'd256);
        chk({name, " first_rd"}, first_rd, {page, 8'h00});
        chk({name, " last_rd"}, last_rd, {page, 8'hFF});
        chk({name, " first_dout"}, {8'd0, wlog[0]}, {8'd0, exp_first});
        chk({name, " last_dout"}, {8'd0, wlog[255]}, {8'd0, exp_last});
        @(negedge clock);
        chk({name, " idle_active"}, {15'd0, dma_active}, 16'd0);
        chk({name, " idle_strobes"}, {14'd0, dma_rd_en, dma_wr_en}, 16'd0);
        chk({name, " hold_addr"}, dma_addr, 16'h2004);
        chk({name, " hold_dout"}, {8'd0, dma_dout}, {8'd0, exp_last});
        $display("%s: page %h active %0d cycles, %0d reads, %0d writes", name, page, len, rd_idx, wr_idx);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cpu_wr_en = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_din   = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst active", {15'd0, dma_active}, 16'd0);
        chk("rst rd_en", {15'd0, dma_rd_en}, 16'd0);
        chk("rst wr_en", {15'd0, dma_wr_en}, 16'd0);
        chk("rst addr", dma_addr, 16'h0000);
        chk("rst dout", {8'd0, dma_dout}, 16'h0000);
        $display("reset: outputs checked");
        reset = 1'b0;

        // First cycle after reset is even; every completed transfer leaves us on an odd cycle.
        run_transfer(8'h02, 513, 0, -1, 8'hA5, 8'h5A, "even_p02");
        run_transfer(8'h02, 514, 0, -1, 8'hA5, 8'h5A, "odd_p02");
        @(negedge clock);
        run_transfer(8'h02, 513, 100, -1, 8'hA5, 8'h5A, "retrigger_p02");
        run_transfer(8'h02, 514, 0, 8'h40, 8'hA5, 8'h5A, "abort_p02");
        run_transfer(8'h02, 513, 0, -1, 8'hA5, 8'h5A, "restart_p02");
        run_transfer(8'hFF, 514, 256, -1, 8'hA5, 8'h80, "vectors_pFF");

        chk("vec FFFA", {8'd0, wlog[250]}, 16'h0010);
        chk("vec FFFB", {8'd0, wlog[251]}, 16'h0080);
        chk("vec FFFC", {8'd0, wlog[252]}, 16'h0000);
        chk("vec FFFD", {8'd0, wlog[253]}, 16'h0080);
        chk("vec FFFE", {8'd0, wlog[254]}, 16'h0020);
        chk("vec FFFF", {8'd0, wlog[255]}, 16'h0080);
        $display("vectors: last six bytes of page FF checked");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014, is the CPU address whose write starts a transfer.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004, is the PPU OAM data port address targeted by DMA writes.
REQ-003 Port clock, input, 1, is the single CPU-domain clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, is a synchronous, active-high reset.
REQ-005 Port cpu_wr_en, input, 1, is the CPU write strobe.
REQ-006 Port cpu_addr, input, 16, is the CPU address.
REQ-007 Port cpu_din, input, 8, is the CPU write data, which carries the source page.
REQ-008 Port bus_din, input, 8, is read data returned by the bus mux (cartridge/RAM) for dma_addr, valid in the same cycle.
REQ-009 Port dma_active, output, 1, is high while DMA owns the bus; it is also the CPU halt request.
REQ-010 Port dma_addr, output, 16, is the bus address driven by DMA.
REQ-011 Port dma_rd_en, output, 1, is high in DMA read cycles.
REQ-012 Port dma_wr_en, output, 1, is high in DMA write cycles.
REQ-013 Port dma_dout, output, 8, is the byte written to OAM_DATA_ADDR.

Function
REQ-014 States SHALL be IDLE, HALT, ALIGN, READ and WRITE.
REQ-015 A parity flop SHALL toggle every cycle; parity 0 is "even"; it is independent of state.
REQ-016 In IDLE, cpu_wr_en=1 with cpu_addr==DMA_REG_ADDR SHALL latch page=cpu_din, clear index to 0 and move to HALT next cycle.
REQ-017 HALT SHALL last exactly one cycle, then go to READ if the next cycle is even, else ALIGN.
REQ-018 ALIGN SHALL last exactly one cycle, then go to READ.
REQ-019 READ: dma_addr={page,index}, dma_rd_en=1; bus_din SHALL be latched into the data register at cycle end; next state WRITE.
REQ-020 WRITE: dma_addr=OAM_DATA_ADDR, dma_wr_en=1, dma_dout=latched byte; index SHALL increment by 1 (8-bit).
REQ-021 On WRITE, if index==8'hFF before increment, the next state SHALL be IDLE; otherwise it SHALL be READ.
REQ-022 Total dma_active duration SHALL be 513 cycles (trigger write on an even cycle) or 514 cycles (trigger on an odd cycle).
REQ-023 dma_active SHALL be 1 in every state except IDLE and SHALL be a decode of the state register (no extra delay).
REQ-024 Writes to DMA_REG_ADDR while not IDLE SHALL be ignored; page and index are unaffected.
REQ-025 A trigger write in the same cycle that WRITE returns to IDLE SHALL be ignored; only a write seen in IDLE starts a transfer.
REQ-026 Outside READ/WRITE: dma_rd_en=0 and dma_wr_en=0; dma_addr and dma_dout hold their last values.
REQ-027 Page 8'hFF SHALL read 16'hFF00-16'hFFFF with no wrap beyond 16 bits.

Reset
REQ-028 Reset SHALL force state=IDLE, parity=0, page=0, index=0, data=0.
REQ-029 Reset SHALL force outputs to: dma_active=0, dma_rd_en=0, dma_wr_en=0, dma_addr=0, dma_dout=0.
REQ-030 Reset asserted mid-transfer SHALL abort in the following cycle with no further bus strobes.
REQ-031 A trigger write coincident with reset SHALL be dropped.

Structure
REQ-032 The shared package nes_pkg SHALL hold the state enum oam_dma_state_t and the constants ADDR_OAMDMA=16'h4014 and ADDR_OAMDATA=16'h2004; parameter defaults SHALL reference them.
REQ-033 The block SHALL be a single module with no sub-module; the bus mux selecting dma_addr over cpu_addr using dma_active lives in the parent.

Verification
REQ-034 Trigger write 8'h02 on an even cycle -> dma_active high for 513 cycles; first READ addr 16'h0200, last 16'h02FF.
REQ-035 Same trigger on an odd cycle -> exactly one ALIGN cycle inserted; dma_active high for 514 cycles.
REQ-036 Memory model returning byte = low address XOR 8'hA5 -> 256 writes to 16'h2004 with dma_dout sequence 8'hA5, 8'hA4, ..., 8'h5A, in order.
REQ-037 Second write to 16'h4014 with 8'h07 at write #100 -> ignored; page stays 8'h02; the transfer completes normally.
REQ-038 Reset pulsed during READ of index 8'h40 -> next cycle dma_active=0 and all strobes 0; a new trigger then restarts at index 0.
REQ-039 Page 8'hFF with ROM vectors loaded -> final reads hit 16'hFFFA-16'hFFFF and return the reset/NMI/IRQ vector bytes.
